aes_round_sched: RTL and testbench

- Controller for an iterative AES round datapath: the datapath contains the state register, round logic and key expansion; this block drives it.
- Accepts one plaintext/key pair on a valid/ready handshake and latches it.
- Sequences the datapath through the load step and NUM_ROUNDS rounds, then captures the result and presents it on a valid/ready output handshake.
- Sits between the system interface and the AES round core inside the AES top level.

---
 rtl/aes_round_sched_pkg.sv | 21 ++
 rtl/aes_round_sched_if.sv | 26 ++
 rtl/aes_round_sched_round_ctr.sv | 60 ++++++
 rtl/aes_round_sched.sv | 155 +++++++++++++++
 tb/tb_aes_round_sched.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_round_sched_pkg.sv
// Shared types and constants for the AES round scheduler.
package aes_sched_pkg;

  localparam int AES_DATA_W    = 128;
  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    CAPTURE,
    HOLD
  } sched_state_e;

  function automatic bit legal_rounds(input int n);
    return (n == AES128_ROUNDS) || (n == AES192_ROUNDS) || (n == AES256_ROUNDS);
  endfunction

endpackage

// File: rtl/aes_round_sched_if.sv
// System-side request/response handshake of the AES round scheduler.
interface aes_round_sched_if
  import aes_sched_pkg::*;
#(
  parameter int DATA_W = AES_DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_plaintext;
  logic [DATA_W-1:0] in_key;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_plaintext, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_round_sched_round_ctr.sv
// Sub-cycle and round counter: dp_round runs 1..NUM_ROUNDS, each held ROUND_CYCLES cycles.
module aes_sched_round_ctr #(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       start_i,
  input  logic       enable_i,
  output logic [3:0] dp_round_o,
  output logic       dp_last_o,
  output logic       round_done_o
);

  localparam int              SUB_W      = $clog2(ROUND_CYCLES + 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(ROUND_CYCLES - 1);
  localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       round_q, round_d;
  logic             sub_wrap;

  assign sub_wrap = (sub_q == SUB_LAST);

  always_comb begin
    sub_d   = sub_q;
    round_d = round_q;
    if (clr_i) begin
      sub_d   = '0;
      round_d = '0;
    end else if (start_i) begin
      sub_d   = '0;
      round_d = 4'd1;
    end else if (enable_i) begin
      if (sub_wrap) begin
        sub_d   = '0;
        // Leaving the final round drops the index back to "not in a round".
        round_d = (round_q == LAST_ROUND) ? 4'd0 : round_q + 4'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      round_q <= '0;
    end else begin
      sub_q   <= sub_d;
      round_q <= round_d;
    end
  end

  assign dp_round_o   = round_q;
  assign dp_last_o    = (round_q == LAST_ROUND);
  assign round_done_o = enable_i && sub_wrap && (round_q == LAST_ROUND);

endmodule

// File: rtl/aes_round_sched.sv
// Controller driving an iterative AES round datapath from block accept to result handshake.
// Defining AES_SCHED_PERF_EN adds cycle_count and block_count outputs.
//
// state   | meaning
// IDLE    | in_ready high, waiting for a block
// LOAD    | datapath loads plaintext ^ key
// ROUND   | round steps 1..NUM_ROUNDS, ROUND_CYCLES cycles each
// CAPTURE | datapath state sampled into out_data
// HOLD    | result presented until out_ready
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int DATA_W       = AES_DATA_W,
  parameter int NUM_ROUNDS   = AES128_ROUNDS,
  parameter int ROUND_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  aes_round_sched_if.slave  sys,
  output logic              dp_load,
  output logic [DATA_W-1:0] dp_pt,
  output logic [DATA_W-1:0] dp_key,
  output logic              dp_round_en,
  output logic [3:0]        dp_round,
  output logic              dp_last,
  input  logic [DATA_W-1:0] dp_result,
  output logic              busy
`ifdef AES_SCHED_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [15:0]       block_count
`endif
);

  if (!legal_rounds(NUM_ROUNDS) || (ROUND_CYCLES < 1)) begin : g_param_check
    $error("aes_round_sched: NUM_ROUNDS must be 10/12/14 and ROUND_CYCLES >= 1");
  end

  sched_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] pt_q, pt_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              round_done;
  logic              out_hs;

  assign out_hs = (state_q == HOLD) && out_valid_q && sys.out_ready;

  aes_sched_round_ctr #(
    .NUM_ROUNDS  (NUM_ROUNDS),
    .ROUND_CYCLES(ROUND_CYCLES)
  ) u_round_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (abort),
    .start_i     ((state_q == LOAD) && !abort),
    .enable_i    ((state_q == ROUND) && !abort),
    .dp_round_o  (dp_round),
    .dp_last_o   (dp_last),
    .round_done_o(round_done)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pt_d        = pt_q;
    key_d       = key_q;
    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (sys.in_valid && in_ready_q) begin
            state_d    = LOAD;
            in_ready_d = 1'b0;
            pt_d       = sys.in_plaintext;
            key_d      = sys.in_key;
          end else begin
            in_ready_d = 1'b1;
          end
        end
        LOAD:  state_d = ROUND;
        ROUND: if (round_done) state_d = CAPTURE;
        CAPTURE: begin
          out_data_d  = dp_result;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: begin
          if (out_hs) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pt_q        <= '0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
    end
  end

  assign sys.in_ready  = in_ready_q;
  assign sys.out_valid = out_valid_q;
  assign sys.out_data  = out_data_q;
  assign dp_pt         = pt_q;
  assign dp_key        = key_q;
  assign dp_load       = (state_q == LOAD);
  assign dp_round_en   = (state_q == ROUND);
  assign busy          = (state_q != IDLE);

`ifdef AES_SCHED_PERF_EN
  logic [31:0] cycle_count_q;
  logic [15:0] block_count_q;

  // Counters survive abort; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      block_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_q + 32'd1;
      if (out_hs && !abort && (block_count_q != 16'hFFFF)) begin
        block_count_q <= block_count_q + 16'd1;
      end
    end
  end

  assign cycle_count = cycle_count_q;
  assign block_count = block_count_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: behavioural AES datapath on the default instance, raw result on a ROUND_CYCLES=3 instance.
module tb_aes_round_sched;
  import aes_sched_pkg::*;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int which = 0;

  aes_round_sched_if #(.DATA_W(128)) if0 ();
  aes_round_sched_if #(.DATA_W(128)) if1 ();

  logic         d0_load, d0_ren, d0_last, d0_busy;
  logic [3:0]   d0_round;
  logic [127:0] d0_pt, d0_key, d0_res;
  logic         d1_load, d1_ren, d1_last, d1_busy;
  logic [3:0]   d1_round;
  logic [127:0] d1_pt, d1_key, d1_res;
`ifdef AES_SCHED_PERF_EN
  logic [31:0]  d0_cyc, d1_cyc;
  logic [15:0]  d0_blk, d1_blk;
  logic [31:0]  edges;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0; else edges <= edges + 1;
`endif

  aes_round_sched u_dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .sys(if0.slave),
    .dp_load(d0_load), .dp_pt(d0_pt), .dp_key(d0_key), .dp_round_en(d0_ren),
    .dp_round(d0_round), .dp_last(d0_last), .dp_result(d0_res), .busy(d0_busy)
`ifdef AES_SCHED_PERF_EN
    , .cycle_count(d0_cyc), .block_count(d0_blk)
`endif
  );

  aes_round_sched #(.ROUND_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .sys(if1.slave),
    .dp_load(d1_load), .dp_pt(d1_pt), .dp_key(d1_key), .dp_round_en(d1_ren),
    .dp_round(d1_round), .dp_last(d1_last), .dp_result(d1_res), .busy(d1_busy)
`ifdef AES_SCHED_PERF_EN
    , .cycle_count(d1_cyc), .block_count(d1_blk)
`endif
  );

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0]  r = 8'h01;
    logic [7:0]  p = x;
    logic [7:0]  s = 8'h63;
    logic [15:0] d;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    d = {r, r};
    for (int k = 0; k < 5; k++) s ^= d[15-k -: 8];
    return s;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input int rnd);
    logic [31:0] w0 = k[127:96], w1 = k[95:64], w2 = k[63:32], w3 = k[31:0];
    logic [31:0] rot, t;
    logic [7:0]  rc = 8'h01;
    for (int j = 1; j < rnd; j++) rc = xt(rc);
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input bit last);
    logic [7:0]   b[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 1; r <= 10; r++) begin
      k = kexp(k, r);
      s = aes_round(s, k, r == 10);
    end
    return s;
  endfunction

  // Round datapath behind the default instance: one AES round per new dp_round value.
  logic [127:0] m_rk;
  logic [3:0]   m_applied;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_res <= '0; m_rk <= '0; m_applied <= '0;
    end else if (d0_load) begin
      d0_res <= d0_pt ^ d0_key; m_rk <= d0_key; m_applied <= '0;
    end else if (d0_ren && d0_round != m_applied) begin
      d0_res    <= aes_round(d0_res, kexp(m_rk, int'(d0_round)), d0_last);
      m_rk      <= kexp(m_rk, int'(d0_round));
      m_applied <= d0_round;
    end
  end

  // ---------------- monitor mux ----------------
  logic         m_in_ready, m_out_valid, m_load, m_ren, m_last, m_busy;
  logic [3:0]   m_round;
  logic [127:0] m_out_data, m_pt, m_key;
  always_comb begin
    m_in_ready = if0.in_ready; m_out_valid = if0.out_valid; m_out_data = if0.out_data;
    m_load = d0_load; m_ren = d0_ren; m_last = d0_last; m_busy = d0_busy;
    m_round = d0_round; m_pt = d0_pt; m_key = d0_key;
    if (which == 1) begin
      m_in_ready = if1.in_ready; m_out_valid = if1.out_valid; m_out_data = if1.out_data;
      m_load = d1_load; m_ren = d1_ren; m_last = d1_last; m_busy = d1_busy;
      m_round = d1_round; m_pt = d1_pt; m_key = d1_key;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_in(input bit v, input logic [127:0] pt, input logic [127:0] key);
    if (which == 0) begin
      if0.in_valid = v; if0.in_plaintext = pt; if0.in_key = key;
    end else begin
      if1.in_valid = v; if1.in_plaintext = pt; if1.in_key = key;
    end
  endtask

  task automatic drive_oready(input bit v);
    if (which == 0) if0.out_ready = v; else if1.out_ready = v;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
    int i = 0;
    @(negedge clk);
    while (!m_in_ready && i < 60) begin
      @(negedge clk);
      i++;
    end
    check_eq("accept_ready", 128'(m_in_ready), 128'(1));
    drive_in(1'b1, pt, key);
    @(posedge clk);
    #1 drive_in(1'b0, pt, key);
    check_eq("latch_pt", m_pt, pt);
    check_eq("latch_key", m_key, key);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int nr, input int rc, input int hold);
    int rounds[$];
    int k = 0, loads = 0, lastn = 0, lastbad = 0, seqbad = 0, stbad = 0;
    logic [127:0] od;
    start_block(pt, key);
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (m_load) loads++;
      if (m_ren) rounds.push_back(int'(m_round));
      if (m_last) begin
        lastn++;
        if (m_round != 4'(nr)) lastbad++;
      end
      if (m_out_valid) break;
    end
    check_eq("latency", 128'(k - 1), 128'(nr * rc + 2));
    check_eq("load_cycles", 128'(loads), 128'(1));
    if (rounds.size() != nr * rc) seqbad++;
    else foreach (rounds[i]) if (rounds[i] != i / rc + 1) seqbad++;
    check_eq("round_seq", 128'(seqbad), 128'(0));
    check_eq("last_cycles", 128'(lastn), 128'(rc));
    check_eq("last_round", 128'(lastbad), 128'(0));
    check_eq("out_data", m_out_data, exp);
    od = m_out_data;
    for (int i = 0; i < hold; i++) begin
      drive_in(i % 3 == 1, rnd128(), rnd128());
      @(negedge clk);
      if (!m_out_valid || m_out_data !== od || m_in_ready || m_pt !== pt || !m_busy) stbad++;
    end
    drive_in(1'b0, pt, key);
    check_eq("hold_stable", 128'(stbad), 128'(0));
    drive_oready(1'b1);
    @(posedge clk);
    #1 drive_oready(1'b0);
    @(negedge clk);
    check_eq("post_hs_in_ready", 128'(m_in_ready), 128'(1));
    check_eq("post_hs_out_valid", 128'(m_out_valid), 128'(0));
    check_eq("post_hs_out_data", m_out_data, od);
  endtask

  initial begin
    logic [127:0] pt, key;
    int k, bad;
    d1_res = rnd128();
    which = 0;
    drive_in(1'b0, '0, '0); drive_oready(1'b0);
    which = 1;
    drive_in(1'b0, '0, '0); drive_oready(1'b0);
    which = 0;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready", 128'(m_in_ready), 128'(0));
    check_eq("rst_out_valid", 128'(m_out_valid), 128'(0));
    check_eq("rst_busy", 128'(m_busy), 128'(0));
    check_eq("rst_round", 128'(m_round), 128'(0));
    check_eq("rst_out_data", m_out_data, 128'(0));
    repeat (2) @(negedge clk);
    check_eq("rst_hold_in_ready", 128'(m_in_ready), 128'(0));
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 128'(m_in_ready), 128'(1));

    // FIPS-197 vector with 20 cycles of backpressure
    run_block(FIPS_PT, FIPS_KEY, FIPS_CT, 10, 1, 20);

    // Multi-cycle rounds
    which = 1;
    run_block(rnd128(), rnd128(), d1_res, 10, 3, 2);
    which = 0;

    for (int n = 0; n < 4; n++) begin
      pt = rnd128(); key = rnd128();
      run_block(pt, key, aes128(pt, key), 10, 1, int'($urandom_range(0, 5)));
    end

    // abort during round 5
    start_block(FIPS_PT, FIPS_KEY);
    k = 0;
    do begin @(negedge clk); k++; end while (m_round != 4'd5 && k < 40);
    check_eq("abort_reach_r5", 128'(m_round), 128'(5));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 128'(m_busy), 128'(0));
    check_eq("abort_round", 128'(m_round), 128'(0));
    check_eq("abort_ren", 128'(m_ren), 128'(0));
    check_eq("abort_in_ready", 128'(m_in_ready), 128'(1));
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (m_out_valid || m_busy) bad++;
    end
    check_eq("abort_no_result", 128'(bad), 128'(0));
    run_block(FIPS_PT, FIPS_KEY, FIPS_CT, 10, 1, 0);

    // async reset during round 7
    start_block(rnd128(), rnd128());
    k = 0;
    do begin @(negedge clk); k++; end while (m_round != 4'd7 && k < 40);
    check_eq("reset_reach_r7", 128'(m_round), 128'(7));
    rst_n = 1'b0;
    #2;
    check_eq("arst_in_ready", 128'(m_in_ready), 128'(0));
    check_eq("arst_busy", 128'(m_busy), 128'(0));
    check_eq("arst_round", 128'(m_round), 128'(0));
    check_eq("arst_ren_last", 128'({m_ren, m_last, m_load}), 128'(0));
    check_eq("arst_out_data", m_out_data, 128'(0));
    check_eq("arst_pt", m_pt, 128'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_rel_in_ready", 128'(m_in_ready), 128'(1));

    run_block(FIPS_PT, FIPS_KEY, FIPS_CT, 10, 1, 0);
    for (int n = 0; n < 2; n++) begin
      pt = rnd128(); key = rnd128();
      run_block(pt, key, aes128(pt, key), 10, 1, 0);
    end
`ifdef AES_SCHED_PERF_EN
    check_eq("perf_block_count", 128'(d0_blk), 128'(3));
    check_eq("perf_cycle_count", 128'(d0_cyc), 128'(edges));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
